inst_dispatch_arbiter: RTL and testbench
========================================

Name: inst_dispatch_arbiter

Overview:
- Clocked scheduler that shares one NoC injection port between N_PE per-PE instruction queues.
- Picks one eligible queue per cycle in round-robin order and tags the packet with its PE node id as {content, PE_node}.
- Gates "new ifmap set" packets (content[1:0]==2'b00) until the target PE has acked the previous set.
- Sits between the per-PE instruction queues and the router injection port.

Parameters:
- WIDTH, 14, instruction content width (filter/ifmap packet formats).
- N_PE, 4, number of requesters/PEs; legal range 2..16.
- PE_ID_W, 4, width of the PE_node tag; N_PE <= 2**PE_ID_W.
- INIT_CREDIT, 1, reset value of every per-PE ack credit bit.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_PE  queue i holds a packet.
- req_data  in  N_PE*WIDTH  packet of queue i, at bits [i*WIDTH +: WIDTH].
- req_ready  out  N_PE  one-hot grant; the packet is consumed when req_valid[i] & req_ready[i].
- pe_ack  in  N_PE  single-cycle pulse: PE i is ready for a new ifmap set.
- out_valid  out  1  output register holds a packet.
- out_data  out  WIDTH+PE_ID_W  {content, PE_node}; PE_node in the low PE_ID_W bits.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- credit  out  N_PE  current ack credit per PE (debug/status).
- ack_overflow  out  1  sticky error flag.
- issue_count  out  16  total packets issued downstream; wraps at 2**16.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, rr_ptr=0.
  - credit={N_PE{INIT_CREDIT[0]}}, ack_overflow=0, issue_count=0.
  - req_ready=0 while reset is asserted.
  - Reset mid-transfer drops the held packet without sending it; queues must re-present.
- Gated packet: req_data[i][1:0]==2'b00. Eligibility: elig[i] = req_valid[i] & (~gated[i] | credit[i]).
- Load window: load_ok = ~out_valid | out_ready.
- Grant (combinational): if load_ok, grant g = first i with elig[i] in order rr_ptr, rr_ptr+1, ... mod N_PE. Then req_ready = onehot(g); otherwise req_ready=0.
  - req_ready may depend on req_valid. Requesters must not wait for req_ready before raising req_valid.
- Grant edge:
  - out_data <= {req_data[g], g zero-extended to PE_ID_W}; out_valid <= 1.
  - rr_ptr <= (g==N_PE-1) ? 0 : g+1.
- No grant while load_ok: out_valid <= 0 if out_ready, else hold. rr_ptr holds.
- Output register is stable (out_valid, out_data) while out_valid & ~out_ready.
- Latency: request to out_valid is 1 cycle. Throughput is 1 packet/cycle under continuous out_ready.
- issue_count increments on each out_valid & out_ready.
- Credit per PE i:
  - pe_ack[i] only: credit <= 1. If credit was already 1, also set ack_overflow <= 1 (sticky until reset).
  - Gated grant of i only: credit <= 0.
  - Both in the same cycle: credit stays 1 (the ack refers to the next set), no overflow.
  - Ungated grant: credit is unchanged.
- A blocked gated head (credit 0) does not stall other queues; rr_ptr skips it.
- FSM (2 states):
  - EMPTY (out_valid=0) -> FULL on grant.
  - FULL -> FULL on drain with grant, or on stall.
  - FULL -> EMPTY on drain without grant.

Decomposition:
- Shared package inst_pkg: packet field constants (TYPE_BIT=0, TIMESTEP_BIT=1, FILTER_ROW range [3:1], IFX [13:8], IFY [7:2]), the gated-type constant 2'b00, PE_ID_W.
- One sub-module rr_arbiter (N parameter): inputs elig and ptr, outputs onehot grant, grant index and any_grant. Reused by other NoC schedulers.

Test Plan:
- Reset with INIT_CREDIT=1; queue 2 presents 0x0004 (gated) -> req_ready=4'b0100, next cycle out_data={0x0004,4'h2}, credit[2]=0.
- All 4 queues present filter packets 0x0003 continuously, out_ready=1 -> grant order 0,1,2,3,0; issue_count=5 after 5 cycles.
- Queue 1 gated with credit 0 and queue 3 filter -> queue 3 granted. Pulse pe_ack[1] -> queue 1 granted the cycle after, credit[1]=0.
- out_ready=0 for 3 cycles with out_valid=1 -> out_data constant, req_ready=0. Release -> next packet loads on the same edge.
- pe_ack[0] pulsed twice with no grant -> ack_overflow=1 after the second pulse. pe_ack[0] coincident with a gated grant of 0 -> credit[0]=1.
- Assert rst_n=0 asynchronously mid-stall -> out_valid=0 immediately, rr_ptr=0, issue_count=0.

Source files
------------

// File: rtl/inst_pkg.sv
// Shared NoC instruction packet definitions: field positions, the gated
// packet type and the dispatch FSM state encoding.
package inst_pkg;

    // Packet field positions within the instruction content
    localparam int TYPE_BIT      = 0;
    localparam int TIMESTEP_BIT  = 1;
    localparam int FILTER_ROW_HI = 3;
    localparam int FILTER_ROW_LO = 1;
    localparam int IFX_HI        = 13;
    localparam int IFX_LO        = 8;
    localparam int IFY_HI        = 7;
    localparam int IFY_LO        = 2;

    // Low two bits of a "new ifmap set" packet; these wait for a PE ack credit
    localparam logic [1:0] GATED_TYPE = 2'b00;

    // Width of the PE node tag appended to every outgoing packet
    localparam int PE_ID_W = 4;

    // Output register occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } disp_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after ptr.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     elig,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any_grant
);

    int idx;

    // Scan from ptr upward with wraparound and take the first eligible slot
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any_grant && elig[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/inst_dispatch_arbiter.sv
// Shares one NoC injection port between N_PE instruction queues. Packets are
// picked round-robin, tagged {content, PE_node}, and new-ifmap-set packets are
// held back until the target PE has acked the previous set.
module inst_dispatch_arbiter #(
    parameter int WIDTH       = 14,
    parameter int N_PE        = 4,
    parameter int PE_ID_W     = inst_pkg::PE_ID_W,
    parameter int INIT_CREDIT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_PE-1:0]         req_valid,
    input  logic [N_PE*WIDTH-1:0]   req_data,
    output logic [N_PE-1:0]         req_ready,
    input  logic [N_PE-1:0]         pe_ack,
    output logic                    out_valid,
    output logic [WIDTH+PE_ID_W-1:0] out_data,
    input  logic                    out_ready,
    output logic [N_PE-1:0]         credit,
    output logic                    ack_overflow,
    output logic [15:0]             issue_count
);

    import inst_pkg::*;

    localparam int PTR_W = $clog2(N_PE);

    disp_state_t       state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  next_ptr;
    logic [N_PE-1:0]   gated;
    logic [N_PE-1:0]   elig;
    logic [N_PE-1:0]   grant;
    logic [PTR_W-1:0]  grant_idx;
    logic              any_grant;
    logic              load_ok;
    logic              do_grant;
    logic [PE_ID_W-1:0] pe_tag;
    logic [WIDTH-1:0]  sel_data;

    // Classify each queue head and decide whether it may compete this cycle
    always_comb begin
        gated = '0;
        elig  = '0;
        for (int i = 0; i < N_PE; i++) begin
            gated[i] = (req_data[i*WIDTH+TYPE_BIT +: 2] == GATED_TYPE);
            elig[i]  = req_valid[i] & (~gated[i] | credit[i]);
        end
    end

    rr_arbiter #(
        .N     (N_PE),
        .PTR_W (PTR_W)
    ) u_rr (
        .elig      (elig),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign out_valid = (state == ST_FULL);
    assign load_ok   = ~out_valid | out_ready;
    assign do_grant  = rst_n & load_ok & any_grant;
    assign req_ready = do_grant ? grant : '0;
    assign next_ptr  = (grant_idx == PTR_W'(N_PE - 1)) ? '0 : grant_idx + PTR_W'(1);
    assign sel_data  = req_data[int'(grant_idx)*WIDTH +: WIDTH];

    // Zero-extend the winning index into the PE node tag
    always_comb begin
        pe_tag = '0;
        pe_tag[PTR_W-1:0] = grant_idx;
    end

    // Output register FSM: load on grant, drain on out_ready, hold on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (do_grant) begin
                        state    <= ST_FULL;
                        out_data <= {sel_data, pe_tag};
                        rr_ptr   <= next_ptr;
                    end
                end
                ST_FULL: begin
                    if (do_grant) begin
                        out_data <= {sel_data, pe_tag};
                        rr_ptr   <= next_ptr;
                    end else if (out_ready) begin
                        state <= ST_EMPTY;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    // Per-PE ack credit: acks restore it, gated grants consume it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit       <= {N_PE{INIT_CREDIT[0]}};
            ack_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < N_PE; i++) begin
                if (pe_ack[i]) begin
                    // An ack alongside a gated grant belongs to the next set
                    credit[i] <= 1'b1;
                    if (credit[i] && !(do_grant && grant[i] && gated[i]))
                        ack_overflow <= 1'b1;
                end else if (do_grant && grant[i] && gated[i]) begin
                    credit[i] <= 1'b0;
                end
            end
        end
    end

    // Count packets accepted downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            issue_count <= '0;
        else if (out_valid && out_ready)
            issue_count <= issue_count + 16'd1;
    end

endmodule

// File: tb/tb_inst_dispatch_arbiter.sv
// Directed bench for inst_dispatch_arbiter: a cycle-by-cycle vector table plus
// hand-written reset sequences.
module tb_inst_dispatch_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [55:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  pe_ack;
    logic        out_valid;
    logic [17:0] out_data;
    logic        out_ready;
    logic [3:0]  credit;
    logic        ack_overflow;
    logic [15:0] issue_count;

    int n_checks = 0;
    int n_fail   = 0;

    inst_dispatch_arbiter #(
        .WIDTH       (14),
        .N_PE        (4),
        .PE_ID_W     (4),
        .INIT_CREDIT (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .pe_ack       (pe_ack),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .credit       (credit),
        .ack_overflow (ack_overflow),
        .issue_count  (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  valid;
        logic [13:0] d3;
        logic [13:0] d2;
        logic [13:0] d1;
        logic [13:0] d0;
        logic [3:0]  ack;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [17:0] exp_od;
        logic [3:0]  exp_cr;
        logic        exp_ovf;
        logic [15:0] exp_ic;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // valid, d3, d2, d1, d0, ack, ordy | rdy, ov, od, credit, ovf, issue_count
        tbl[0]  = '{4'hF, 14'h3, 14'h3, 14'h3, 14'h3, 4'h0, 1'b1, 4'b0001, 1'b1, 18'h030, 4'hF, 1'b0, 16'd0};
        tbl[1]  = '{4'hF, 14'h3, 14'h3, 14'h3, 14'h3, 4'h0, 1'b1, 4'b0010, 1'b1, 18'h031, 4'hF, 1'b0, 16'd1};
        tbl[2]  = '{4'hF, 14'h3, 14'h3, 14'h3, 14'h3, 4'h0, 1'b1, 4'b0100, 1'b1, 18'h032, 4'hF, 1'b0, 16'd2};
        tbl[3]  = '{4'hF, 14'h3, 14'h3, 14'h3, 14'h3, 4'h0, 1'b1, 4'b1000, 1'b1, 18'h033, 4'hF, 1'b0, 16'd3};
        tbl[4]  = '{4'hF, 14'h3, 14'h3, 14'h3, 14'h3, 4'h0, 1'b1, 4'b0001, 1'b1, 18'h030, 4'hF, 1'b0, 16'd4};
        tbl[5]  = '{4'h0, 14'h0, 14'h0, 14'h0, 14'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 18'h030, 4'hF, 1'b0, 16'd5};
        // gated packets and credit consumption / restoration
        tbl[6]  = '{4'h4, 14'h0, 14'h4, 14'h0, 14'h0, 4'h0, 1'b1, 4'b0100, 1'b1, 18'h042, 4'hB, 1'b0, 16'd5};
        tbl[7]  = '{4'h2, 14'h0, 14'h0, 14'h8, 14'h0, 4'h0, 1'b1, 4'b0010, 1'b1, 18'h081, 4'h9, 1'b0, 16'd6};
        tbl[8]  = '{4'hA, 14'h3, 14'h0, 14'h8, 14'h0, 4'h0, 1'b1, 4'b1000, 1'b1, 18'h033, 4'h9, 1'b0, 16'd7};
        tbl[9]  = '{4'h2, 14'h0, 14'h0, 14'h8, 14'h0, 4'h2, 1'b1, 4'b0000, 1'b0, 18'h033, 4'hB, 1'b0, 16'd8};
        tbl[10] = '{4'h2, 14'h0, 14'h0, 14'h8, 14'h0, 4'h0, 1'b1, 4'b0010, 1'b1, 18'h081, 4'h9, 1'b0, 16'd8};
        // three-cycle downstream stall, then release loads on the same edge
        tbl[11] = '{4'h1, 14'h0, 14'h0, 14'h0, 14'h3, 4'h0, 1'b0, 4'b0000, 1'b1, 18'h081, 4'h9, 1'b0, 16'd8};
        tbl[12] = '{4'h1, 14'h0, 14'h0, 14'h0, 14'h3, 4'h0, 1'b0, 4'b0000, 1'b1, 18'h081, 4'h9, 1'b0, 16'd8};
        tbl[13] = '{4'h1, 14'h0, 14'h0, 14'h0, 14'h3, 4'h0, 1'b0, 4'b0000, 1'b1, 18'h081, 4'h9, 1'b0, 16'd8};
        tbl[14] = '{4'h1, 14'h0, 14'h0, 14'h0, 14'h3, 4'h0, 1'b1, 4'b0001, 1'b1, 18'h030, 4'h9, 1'b0, 16'd9};
        tbl[15] = '{4'h0, 14'h0, 14'h0, 14'h0, 14'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 18'h030, 4'h9, 1'b0, 16'd10};
        // ack coincident with gated grant keeps credit, no overflow
        tbl[16] = '{4'h1, 14'h0, 14'h0, 14'h0, 14'h4, 4'h1, 1'b1, 4'b0001, 1'b1, 18'h040, 4'h9, 1'b0, 16'd10};
        tbl[17] = '{4'h1, 14'h0, 14'h0, 14'h0, 14'h4, 4'h0, 1'b1, 4'b0001, 1'b1, 18'h040, 4'h8, 1'b0, 16'd11};
        // two acks with no grant in between: second one overflows
        tbl[18] = '{4'h0, 14'h0, 14'h0, 14'h0, 14'h0, 4'h1, 1'b1, 4'b0000, 1'b0, 18'h040, 4'h9, 1'b0, 16'd12};
        tbl[19] = '{4'h0, 14'h0, 14'h0, 14'h0, 14'h0, 4'h1, 1'b1, 4'b0000, 1'b0, 18'h040, 4'h9, 1'b1, 16'd12};
        tbl[20] = '{4'h0, 14'h0, 14'h0, 14'h0, 14'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 18'h040, 4'h9, 1'b1, 16'd12};

        // Reset state, with a request present to show req_ready is held low
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = {4{14'h0003}};
        pe_ack    = 4'h0;
        out_ready = 1'b1;
        #12;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data",  32'(out_data),  32'h0);
        check("rst_credit",    32'(credit),    32'hF);
        check("rst_overflow",  32'(ack_overflow), 32'h0);
        check("rst_issue_cnt", 32'(issue_count),  32'h0);
        req_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: drive after an edge, check grant mid-cycle, check state after next edge
        for (int i = 0; i < 21; i++) begin
            req_valid = tbl[i].valid;
            req_data  = {tbl[i].d3, tbl[i].d2, tbl[i].d1, tbl[i].d0};
            pe_ack    = tbl[i].ack;
            out_ready = tbl[i].ordy;
            @(negedge clk);
            check($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            check($sformatf("v%0d_out_data", i),  32'(out_data),  32'(tbl[i].exp_od));
            check($sformatf("v%0d_credit", i),    32'(credit),    32'(tbl[i].exp_cr));
            check($sformatf("v%0d_overflow", i),  32'(ack_overflow), 32'(tbl[i].exp_ovf));
            check($sformatf("v%0d_issue_cnt", i), 32'(issue_count),  32'(tbl[i].exp_ic));
        end

        // Asynchronous reset in the middle of a stall drops the held packet
        req_valid = 4'h1;
        req_data  = {14'h0, 14'h0, 14'h0, 14'h0003};
        pe_ack    = 4'h0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 4'h0;
        check("stall_out_valid", 32'(out_valid), 32'h1);
        check("stall_out_data",  32'(out_data),  32'h030);
        @(posedge clk);
        #2;
        check("stall_hold_data", 32'(out_data),    32'h030);
        check("pre_rst_issue",   32'(issue_count), 32'd12);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid),    32'h0);
        check("arst_out_data",  32'(out_data),     32'h0);
        check("arst_issue_cnt", 32'(issue_count),  32'h0);
        check("arst_credit",    32'(credit),       32'hF);
        check("arst_overflow",  32'(ack_overflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Pointer restarts at 0 after reset
        req_valid = 4'hF;
        req_data  = {4{14'h0003}};
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_grant", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        check("post_rst_data",  32'(out_data),    32'h030);
        check("post_rst_issue", 32'(issue_count), 32'h0);
        req_valid = 4'h0;
        @(negedge clk);
        check("post_rst_grant2", 32'(req_ready), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
